avg_sched: RTL and testbench

Round-robin scheduler that shares a single closest-to-mean selection engine among N_CH independent 16-bit sample streams. Each channel has its own 12-entry sliding window, fill count and running sum. Once a channel's window is full, every accepted sample triggers a sequenced scan: compute the window average, walk the window once, and emit the sample value closest to that average. The block sits between the sample producers and the downstream result consumer.

---
 rtl/avg_pkg.sv | 20 ++
 rtl/avg_rr_arb.sv | 28 ++
 rtl/avg_sched.sv | 194 +++++++++++++++++++
 tb/tb_avg_sched.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avg_pkg.sv
// Shared constants, FSM state type and the divide-by-12 helper for avg_sched.
package avg_pkg;

  localparam int unsigned WIN_DEPTH = 12;
  localparam int unsigned SAMPLE_W  = 16;
  localparam int unsigned SUM_W     = 20;

  typedef enum logic [1:0] {
    StIdle,
    StAvg,
    StScan,
    StResult
  } state_e;

  // 12 * 65535 / 12 still fits in SAMPLE_W, so truncation loses nothing.
  function automatic logic [SAMPLE_W-1:0] div12(input logic [SUM_W-1:0] sum);
    return SAMPLE_W'(sum / SUM_W'(WIN_DEPTH));
  endfunction

endpackage

// File: rtl/avg_rr_arb.sv
// Combinational round-robin grant: first asserted request at or after i_ptr, wrapping.
module avg_rr_arb #(
  parameter int unsigned N_CH = 4
) (
  input  logic [N_CH-1:0]         i_req,
  input  logic [$clog2(N_CH)-1:0] i_ptr,
  output logic [N_CH-1:0]         o_gnt
);

  localparam int unsigned CH_W = $clog2(N_CH);

  logic            w_found;
  logic [CH_W-1:0] w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      w_idx = CH_W'((int'(i_ptr) + k) % int'(N_CH));
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/avg_sched.sv
// Round-robin scheduler sharing one closest-to-mean engine across N_CH 12-deep windows.
// Optional per-channel window flush input is enabled by defining AVG_SCHED_FLUSH_EN.
module avg_sched
  import avg_pkg::*;
#(
  parameter int unsigned N_CH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          i_in_valid,
  input  logic [SAMPLE_W*N_CH-1:0] i_in_data,
  output logic [N_CH-1:0]          o_in_ready,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [$clog2(N_CH)-1:0]  o_out_ch,
  output logic [SAMPLE_W-1:0]      o_out_data,
  output logic                     o_busy
`ifdef AVG_SCHED_FLUSH_EN
  ,
  input  logic [N_CH-1:0]          i_flush
`endif
);

  localparam int unsigned CH_W     = $clog2(N_CH);
  localparam logic [3:0]  LAST_IDX = 4'(WIN_DEPTH - 1);
  localparam logic [3:0]  FULL     = 4'(WIN_DEPTH);

  state_e r_state, w_state_nxt;

  logic [SAMPLE_W-1:0] r_buf  [N_CH][WIN_DEPTH];
  logic [3:0]          r_wptr [N_CH];
  logic [3:0]          r_fill [N_CH];
  logic [SUM_W-1:0]    r_sum  [N_CH];

  logic [CH_W-1:0]     r_rr_ptr;
  logic [CH_W-1:0]     r_cur_ch;
  logic [CH_W-1:0]     r_out_ch;
  logic [SAMPLE_W-1:0] r_avg;
  logic [SAMPLE_W-1:0] r_best_val;
  logic [SAMPLE_W:0]   r_best_dist;
  logic [SAMPLE_W-1:0] r_out_data;
  logic [3:0]          r_scan_idx;

  logic [N_CH-1:0]     w_gnt;
  logic [N_CH-1:0]     w_flush;
  logic                w_flush_any;
  logic                w_idle;
  logic                w_xfer;
  logic                w_full_after;
  logic [CH_W-1:0]     w_gidx;
  logic [CH_W-1:0]     w_rr_nxt;
  logic [SAMPLE_W-1:0] w_din;
  logic [SAMPLE_W-1:0] w_entry;
  logic [SAMPLE_W:0]   w_dist;
  logic                w_take;

`ifdef AVG_SCHED_FLUSH_EN
  assign w_flush = i_flush;
`else
  assign w_flush = '0;
`endif

  assign w_flush_any = |w_flush;
  assign w_idle      = (r_state == StIdle);

  avg_rr_arb #(
    .N_CH (N_CH)
  ) u_arb (
    .i_req (i_in_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt)
  );

  always_comb begin
    w_gidx = '0;
    w_din  = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (w_gnt[i]) begin
        w_gidx = CH_W'(i);
        w_din  = i_in_data[i*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  // Flush wins over accept, so the grant is masked in a flush cycle.
  assign w_xfer       = w_idle && !w_flush_any && (|w_gnt);
  assign o_in_ready   = (w_idle && !w_flush_any) ? w_gnt : '0;
  assign w_full_after = (r_fill[w_gidx] >= LAST_IDX);
  assign w_rr_nxt     = (w_gidx == CH_W'(N_CH - 1)) ? '0 : w_gidx + CH_W'(1);

  assign w_entry = r_buf[r_cur_ch][r_scan_idx];
  assign w_dist  = (w_entry >= r_avg) ? ({1'b0, w_entry} - {1'b0, r_avg})
                                      : ({1'b0, r_avg} - {1'b0, w_entry});
  assign w_take  = (w_dist < r_best_dist) ||
                   ((w_dist == r_best_dist) && (w_entry < r_best_val));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (w_xfer && w_full_after) w_state_nxt = StAvg;
      StAvg:    w_state_nxt = StScan;
      StScan:   if (r_scan_idx == LAST_IDX) w_state_nxt = StResult;
      StResult: if (i_out_ready) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // Sample storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_buf[w_gidx][r_wptr[w_gidx]] <= w_din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        r_wptr[i] <= '0;
        r_fill[i] <= '0;
        r_sum[i]  <= '0;
      end
      r_rr_ptr <= '0;
      r_cur_ch <= '0;
    end else if (w_idle) begin
      if (w_flush_any) begin
        for (int i = 0; i < int'(N_CH); i++) begin
          if (w_flush[i]) begin
            r_wptr[i] <= '0;
            r_fill[i] <= '0;
            r_sum[i]  <= '0;
          end
        end
      end else if (w_xfer) begin
        r_wptr[w_gidx] <= (r_wptr[w_gidx] == LAST_IDX) ? '0 : r_wptr[w_gidx] + 4'd1;
        if (r_fill[w_gidx] < FULL) begin
          r_sum[w_gidx]  <= r_sum[w_gidx] + SUM_W'(w_din);
          r_fill[w_gidx] <= r_fill[w_gidx] + 4'd1;
        end else begin
          // wptr points at the oldest entry once the window is full.
          r_sum[w_gidx] <= r_sum[w_gidx] + SUM_W'(w_din)
                           - SUM_W'(r_buf[w_gidx][r_wptr[w_gidx]]);
        end
        r_rr_ptr <= w_rr_nxt;
        r_cur_ch <= w_gidx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_avg       <= '0;
      r_scan_idx  <= '0;
      r_best_dist <= '0;
      r_best_val  <= '0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else begin
      case (r_state)
        StAvg: begin
          r_avg       <= div12(r_sum[r_cur_ch]);
          r_scan_idx  <= '0;
          r_best_dist <= '1;
          r_best_val  <= '1;
        end
        StScan: begin
          r_scan_idx <= r_scan_idx + 4'd1;
          if (w_take) begin
            r_best_dist <= w_dist;
            r_best_val  <= w_entry;
          end
          if (r_scan_idx == LAST_IDX) begin
            r_out_data <= w_take ? w_entry : r_best_val;
            r_out_ch   <= r_cur_ch;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_out_valid = (r_state == StResult);
  assign o_busy      = !w_idle;
  assign o_out_ch    = r_out_ch;
  assign o_out_data  = r_out_data;

endmodule

// File: tb/tb_avg_sched.sv
// Self-checking bench for avg_sched: table vectors, directed corner sequences, random traffic.
module tb_avg_sched;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    in_valid;
  logic [16*N-1:0] in_data;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_ch;
  logic [15:0]     out_data;
  logic            busy;
`ifdef AVG_SCHED_FLUSH_EN
  logic [N-1:0]    flush;
`endif

  avg_sched #(
    .N_CH (N)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_in_valid  (in_valid),
    .i_in_data   (in_data),
    .o_in_ready  (in_ready),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_ch    (out_ch),
    .o_out_data  (out_data),
    .o_busy      (busy)
`ifdef AVG_SCHED_FLUSH_EN
    ,
    .i_flush     (flush)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: per-channel window kept oldest-first, shifted on each new sample.
  int win [N][12];
  int cnt [N];
  int m_rr;

  typedef struct packed {
    logic [1:0]   ch;
    logic [191:0] s;
    logic [15:0]  exp;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) cnt[c] = 0;
    m_rr = 0;
  endtask

  task automatic model_push(input int ch, input int val, output bit has, output int exp);
    int sum, avg, bd, best, d;
    if (cnt[ch] < 12) begin
      win[ch][cnt[ch]] = val;
      cnt[ch]++;
    end else begin
      for (int k = 0; k < 11; k++) win[ch][k] = win[ch][k+1];
      win[ch][11] = val;
    end
    m_rr = (ch + 1) % N;
    has  = (cnt[ch] == 12);
    exp  = -1;
    if (has) begin
      sum = 0;
      for (int k = 0; k < 12; k++) sum += win[ch][k];
      avg  = sum / 12;
      bd   = 1 << 30;
      best = 0;
      for (int k = 0; k < 12; k++) begin
        d = (win[ch][k] >= avg) ? win[ch][k] - avg : avg - win[ch][k];
        if (d < bd || (d == bd && win[ch][k] < best)) begin
          bd   = d;
          best = win[ch][k];
        end
      end
      exp = best;
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++) begin
      if (mask[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  task automatic wait_ready(output bit ok);
    int n = 0;
    @(negedge clk);
    while (in_ready == '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    ok = (in_ready != '0);
    if (!ok) timeout_fail("grant_timeout");
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (!out_valid && c < 60) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("released", out_valid, 0);
  endtask

  task automatic finish_xfer(input int ch, input bit has, input int exp, output int got);
    int cyc;
    got = -1;
    if (has) begin
      wait_valid(cyc);
      chk("latency", cyc, 13);
      chk("out_ch", out_ch, ch);
      chk("out_data", out_data, exp);
      got = int'(out_data);
      release_result();
    end else begin
      chk("warm_no_valid", out_valid, 0);
      chk("warm_busy", busy, 0);
    end
  endtask

  task automatic accept_one(input int ch, input int val, output int got);
    bit ok, has;
    int exp;
    in_data[16*ch +: 16] = 16'(val);
    in_valid             = '0;
    in_valid[ch]         = 1'b1;
    wait_ready(ok);
    if (!ok) begin
      in_valid = '0;
      got      = -1;
      return;
    end
    chk("grant", in_ready, 1 << ch);
    @(posedge clk);
    #1;
    in_valid = '0;
    model_push(ch, val, has, exp);
    finish_xfer(ch, has, exp, got);
  endtask

  task automatic evict_and_hold();
    bit ok, has;
    int exp, cyc;
    in_data[15:0] = 16'd100;
    in_valid      = 4'b0001;
    wait_ready(ok);
    chk("evict_grant", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = '0;
    model_push(0, 100, has, exp);
    wait_valid(cyc);
    chk("evict_latency", cyc, 13);
    chk("evict_data", out_data, 12);
    chk("evict_vs_model", out_data, exp);
    chk("evict_ch", out_ch, 0);
    in_valid = '1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, 12);
      chk("hold_ch", out_ch, 0);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = '0;
    release_result();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  got, g, val, exp;
    bit  ok, has;
    logic [N-1:0] mask;
    int  rr_order [5] = '{0, 1, 2, 3, 0};

    for (int k = 0; k < 12; k++) begin
      vecs[0].s[16*k +: 16] = 16'(k + 1);
      vecs[1].s[16*k +: 16] = (k % 2 == 0) ? 16'd4 : 16'd8;
      vecs[2].s[16*k +: 16] = 16'hFFFF;
      vecs[3].s[16*k +: 16] = (k == 11) ? 16'hFFFF : 16'd0;
    end
    vecs[0].ch = 2'd0; vecs[0].exp = 16'd6;
    vecs[1].ch = 2'd1; vecs[1].exp = 16'd4;
    vecs[2].ch = 2'd2; vecs[2].exp = 16'hFFFF;
    vecs[3].ch = 2'd3; vecs[3].exp = 16'd0;

    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef AVG_SCHED_FLUSH_EN
    flush     = '0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_ch", out_ch, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Fresh windows per channel; the 12th sample produces the tabulated result.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 12; k++) begin
        accept_one(int'(vecs[i].ch), int'(vecs[i].s[16*k +: 16]), got);
      end
      chk("table_result", got, 32'(vecs[i].exp));
      if (i == 0) evict_and_hold();
    end

    // All channels valid continuously; rr pointer is 0 after the ch3 accept.
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < N; c++) in_data[16*c +: 16] = 16'($urandom_range(0, 300));
      in_valid = '1;
      wait_ready(ok);
      g = rr_pick('1);
      chk("rr_seq", in_ready, 1 << rr_order[n]);
      val = int'(in_data[16*g +: 16]);
      @(posedge clk);
      #1;
      model_push(g, val, has, exp);
      finish_xfer(g, has, exp, got);
    end
    in_valid = '0;

    // Reset in the middle of a scan.
    in_data[15:0] = 16'd500;
    in_valid      = 4'b0001;
    wait_ready(ok);
    @(posedge clk);
    #1;
    in_valid = '0;
    repeat (5) @(posedge clk);
    #1;
    chk("scan_busy", busy, 1);
    chk("scan_no_valid", out_valid, 0);
    reset = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    in_valid = '1;
    @(negedge clk);
    chk("rst_rr_ptr", in_ready, 1);
    in_valid = '0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 12; k++) accept_one(0, int'($urandom_range(0, 1000)), got);

`ifdef AVG_SCHED_FLUSH_EN
    for (int k = 0; k < 12; k++) accept_one(2, int'($urandom_range(0, 1000)), got);
    in_data[47:32] = 16'd7;
    in_valid       = 4'b0100;
    flush          = 4'b0100;
    @(negedge clk);
    chk("flush_blocks_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush    = '0;
    in_valid = '0;
    cnt[2]   = 0;
    for (int k = 0; k < 12; k++) accept_one(2, int'($urandom_range(0, 1000)), got);
`endif

    // Random traffic against the model, small values mixed in to provoke ties.
    for (int it = 0; it < 150; it++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int c = 0; c < N; c++) begin
        in_data[16*c +: 16] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535))
                                                          : 16'($urandom_range(0, 40));
      end
      in_valid = mask;
      wait_ready(ok);
      g = rr_pick(mask);
      chk("rand_grant", in_ready, 1 << g);
      val = int'(in_data[16*g +: 16]);
      @(posedge clk);
      #1;
      in_valid = '0;
      model_push(g, val, has, exp);
      finish_xfer(g, has, exp, got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
